// File: rtl/instruction_fetch.sv
// Fetch stage: sequential instruction memory reads into a small FIFO, presented
// to decode with their addresses over valid/ready; handles redirects and HLT.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_RDATA,
  output logic [15:0] EXEC,
  output logic [15:0] EXEC_PC,
  output logic        EXEC_VALID,
  input  logic        EXEC_READY,
  input  logic        REDIRECT,
  input  logic [15:0] REDIRECT_PC,
  output logic        HALTED
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        pc_reg, pc_next;
  logic               req_reg, req_next;
  logic [15:0]        addr_reg, addr_next;

  logic [31:0]        buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next, count_after_pop;

  logic [15:0]        exec_reg, exec_next;
  logic [15:0]        exec_pc_reg, exec_pc_next;
  logic               exec_valid_reg, exec_valid_next;
  logic               halted_reg;

  logic               push, pop, is_hlt;
  logic [31:0]        head_word;

  assign is_hlt = (IMEM_RDATA[15:14] == 2'b11) && (IMEM_RDATA[7:4] == 4'hF);
  assign pop    = exec_valid_reg & EXEC_READY;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Nothing is outstanding here, so credit is just free FIFO space.
        if (REDIRECT) begin
          pc_next = REDIRECT_PC;
        end else if (count_reg < CNT_W'(BUF_DEPTH)) begin
          req_next   = 1'b1;
          addr_next  = pc_reg;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (IMEM_ACK) begin
          req_next = 1'b0;
          if (REDIRECT) begin
            pc_next    = REDIRECT_PC;
            state_next = IDLE;
          end else begin
            push       = 1'b1;
            pc_next    = pc_reg + 16'd1;
            state_next = is_hlt ? HALT : IDLE;
          end
        end else if (REDIRECT) begin
          pc_next    = REDIRECT_PC;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (REDIRECT) pc_next = REDIRECT_PC;
        if (IMEM_ACK) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      HALT: begin
        if (REDIRECT) begin
          pc_next    = REDIRECT_PC;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The output register is loaded with the post-edge head, bypassing the
  // array when the incoming word lands directly at the head.
  always_comb begin
    count_after_pop = count_reg - CNT_W'(pop);
    rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
    wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
    count_next      = count_after_pop + CNT_W'(push);
    head_word       = (push && (count_after_pop == '0)) ? {IMEM_RDATA, pc_reg}
                                                        : buf_mem[rd_ptr_next];
    exec_valid_next = (count_next != '0);
    exec_next       = exec_reg;
    exec_pc_next    = exec_pc_reg;
    if (exec_valid_next) {exec_next, exec_pc_next} = head_word;
    if (REDIRECT) begin
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      count_next      = '0;
      exec_valid_next = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      req_reg        <= 1'b0;
      addr_reg       <= RESET_PC;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      exec_reg       <= 16'h0000;
      exec_pc_reg    <= 16'h0000;
      exec_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      req_reg        <= req_next;
      addr_reg       <= addr_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      exec_reg       <= exec_next;
      exec_pc_reg    <= exec_pc_next;
      exec_valid_reg <= exec_valid_next;
      halted_reg     <= (state_next == HALT);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) buf_mem[wr_ptr_reg] <= {IMEM_RDATA, pc_reg};
  end

  assign IMEM_REQ   = req_reg;
  assign IMEM_ADDR  = addr_reg;
  assign EXEC       = exec_reg;
  assign EXEC_PC    = exec_pc_reg;
  assign EXEC_VALID = exec_valid_reg;
  assign HALTED     = halted_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a stream-level
// model: delivered words follow sequentially from the last redirect target.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [15:0] IMEM_RDATA = 16'h0000;
  logic [15:0] EXEC;
  logic [15:0] EXEC_PC;
  logic        EXEC_VALID;
  logic        EXEC_READY = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [15:0] REDIRECT_PC = 16'h0000;
  logic        HALTED;

  instruction_fetch #(.RESET_PC(16'h0000), .BUF_DEPTH(DEPTH)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .EXEC(EXEC), .EXEC_PC(EXEC_PC), .EXEC_VALID(EXEC_VALID),
    .EXEC_READY(EXEC_READY),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .HALTED(HALTED)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;

  // memory responder configuration
  int          mem_lat = 0;
  bit          mem_rand = 0;
  bit          noise_en = 0;
  int          age = 0;
  int          cur_lat = 0;
  bit          hlt_en = 0;
  logic [15:0] hlt_addr = 16'h0003;

  // reference model state
  int          occ = 0;
  logic [15:0] cons_pc = 16'h0000;
  logic [15:0] fetch_pc = 16'h0000;
  logic [15:0] addr_prev = 16'h0000;
  bit          halt_exp = 0;
  bit          stale = 0;
  bit          req_open = 0;
  int          cycle = 0;
  int          acc_cnt = 0;
  int          cons_total = 0;
  int          hs_cyc[$];
  logic [15:0] hs_pc[$];
  logic [15:0] hs_data[$];

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hC0F0;
    return {4'hA, a[11:0]};
  endfunction

  function automatic bit is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the present cycle, then advances the model across the coming edge.
  task automatic monitor();
    bit cons, acc;
    cycle++;
    if (RESET) begin
      occ = 0; cons_pc = 16'h0000; fetch_pc = 16'h0000;
      halt_exp = 0; stale = 0; req_open = 0;
      return;
    end
    chk("exec_valid", 32'(EXEC_VALID), 32'(occ != 0));
    if (occ != 0) begin
      chk("exec_pc", 32'(EXEC_PC), 32'(cons_pc));
      chk("exec_word", 32'(EXEC), 32'(word_at(cons_pc)));
    end
    chk("halted", 32'(HALTED), 32'(halt_exp));
    if (IMEM_REQ) begin
      if (!req_open) begin
        chk("req_addr", 32'(IMEM_ADDR), 32'(fetch_pc));
        chk("req_credit", 32'(occ < DEPTH), 32'd1);
        chk("req_in_halt", 32'(halt_exp), 32'd0);
        stale = 0;
      end else begin
        chk("req_addr_stable", 32'(IMEM_ADDR), 32'(addr_prev));
      end
    end
    cons = (occ != 0) && EXEC_READY;
    acc  = IMEM_REQ && IMEM_ACK && !stale && !REDIRECT;
    if (cons) begin
      hs_cyc.push_back(cycle); hs_pc.push_back(EXEC_PC); hs_data.push_back(EXEC);
      cons_pc++; occ--; cons_total++;
    end
    if (acc) begin
      if (is_hlt(word_at(IMEM_ADDR))) halt_exp = 1;
      fetch_pc++; occ++; acc_cnt++;
    end
    if (IMEM_REQ && REDIRECT) stale = 1;
    if (REDIRECT) begin
      occ = 0; cons_pc = REDIRECT_PC; fetch_pc = REDIRECT_PC; halt_exp = 0;
    end
    req_open  = IMEM_REQ && !IMEM_ACK;
    addr_prev = IMEM_ADDR;
  endtask

  task automatic respond();
    if (!IMEM_REQ) begin
      age        = 0;
      IMEM_ACK   = noise_en && ($urandom_range(0, 3) == 0);
      IMEM_RDATA = 16'($urandom);
    end else begin
      if (age == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      IMEM_ACK   = (age >= cur_lat);
      IMEM_RDATA = IMEM_ACK ? word_at(IMEM_ADDR) : 16'($urandom);
      age++;
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
    monitor();
    @(posedge CLOCK);
    #1;
    respond();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_new_req(input string tag);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      bit prev;
      prev = IMEM_REQ;
      tick();
      if (IMEM_REQ && !prev) got = 1;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (EXEC_VALID) got = 1;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    REDIRECT = 1'b1; REDIRECT_PC = pc;
    tick();
    REDIRECT = 1'b0;
  endtask

  initial begin
    int req_cycles;

    // reset and zero-wait sequential fetch
    EXEC_READY = 1'b1;
    ticks(3);
    chk("rst_req", 32'(IMEM_REQ), 32'd0);
    chk("rst_addr", 32'(IMEM_ADDR), 32'h0000);
    chk("rst_valid", 32'(EXEC_VALID), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    RESET = 1'b0;
    tick();
    chk("first_req", 32'(IMEM_REQ), 32'd1);
    chk("first_addr", 32'(IMEM_ADDR), 32'h0000);
    hs_cyc.delete(); hs_pc.delete(); hs_data.delete();
    ticks(8);
    chk("t1_count", 32'(hs_pc.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < hs_pc.size(); k++) begin
      chk("t1_pc", 32'(hs_pc[k]), 32'(k));
      chk("t1_word", 32'(hs_data[k]), 32'(16'hA000 + 16'(k)));
      if (k > 0) chk("t1_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd2);
    end

    // consumer stall: fill exactly to depth, then drain in order
    EXEC_READY = 1'b0;
    redirect_to(16'h0000);
    acc_cnt = 0;
    ticks(10);
    chk("t2_accepted", 32'(acc_cnt), 32'(DEPTH));
    chk("t2_req_idle", 32'(IMEM_REQ), 32'd0);
    chk("t2_hold_valid", 32'(EXEC_VALID), 32'd1);
    chk("t2_hold_pc", 32'(EXEC_PC), 32'h0000);
    chk("t2_hold_word", 32'(EXEC), 32'hA000);
    hs_cyc.delete(); hs_pc.delete(); hs_data.delete();
    EXEC_READY = 1'b1;
    ticks(8);
    chk("t2_count", 32'(hs_pc.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < hs_pc.size(); k++)
      chk("t2_order", 32'(hs_pc[k]), 32'(k));

    // redirect during an outstanding slow request
    mem_lat = 2;
    redirect_to(16'h0005);
    wait_new_req("t3_req5");
    chk("t3_addr5", 32'(IMEM_ADDR), 32'h0005);
    tick();
    redirect_to(16'h0040);
    chk("t3_drain_req", 32'(IMEM_REQ), 32'd1);
    chk("t3_drain_addr", 32'(IMEM_ADDR), 32'h0005);
    wait_new_req("t3_req40");
    chk("t3_addr40", 32'(IMEM_ADDR), 32'h0040);
    wait_valid("t3_valid");
    chk("t3_exec_pc", 32'(EXEC_PC), 32'h0040);
    chk("t3_exec_word", 32'(EXEC), 32'hA040);

    // redirect coinciding with ACK
    wait_new_req("t4_req");
    ticks(2);
    redirect_to(16'h0100);
    chk("t4_no_push", 32'(EXEC_VALID), 32'd0);
    chk("t4_req_drop", 32'(IMEM_REQ), 32'd0);
    wait_new_req("t4_req100");
    chk("t4_addr100", 32'(IMEM_ADDR), 32'h0100);
    wait_valid("t4_valid");
    chk("t4_exec_pc", 32'(EXEC_PC), 32'h0100);

    // HLT at 0003
    mem_lat = 0; hlt_en = 1; hlt_addr = 16'h0003;
    redirect_to(16'h0000);
    hs_cyc.delete(); hs_pc.delete(); hs_data.delete();
    ticks(20);
    chk("t5_count", 32'(hs_pc.size() >= 1), 32'd1);
    if (hs_pc.size() >= 1) begin
      chk("t5_last_pc", 32'(hs_pc[hs_pc.size()-1]), 32'h0003);
      chk("t5_last_word", 32'(hs_data[hs_data.size()-1]), 32'hC0F0);
    end
    chk("t5_halted", 32'(HALTED), 32'd1);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (IMEM_REQ) req_cycles++;
    end
    chk("t5_no_req", 32'(req_cycles), 32'd0);
    hlt_en = 0;
    redirect_to(16'h0010);
    chk("t5_unhalt", 32'(HALTED), 32'd0);
    wait_new_req("t5_req10");
    chk("t5_addr10", 32'(IMEM_ADDR), 32'h0010);

    // PC wrap
    redirect_to(16'hFFFF);
    wait_valid("t6_valid");
    chk("t6_exec_pc", 32'(EXEC_PC), 32'hFFFF);
    chk("t6_exec_word", 32'(EXEC), 32'hAFFF);
    wait_new_req("t6_req0");
    chk("t6_addr_wrap", 32'(IMEM_ADDR), 32'h0000);

    // asynchronous reset mid-request
    mem_lat = 3;
    wait_new_req("t7_req");
    tick();
    RESET = 1'b1;
    #1;
    chk("t7_req", 32'(IMEM_REQ), 32'd0);
    chk("t7_addr", 32'(IMEM_ADDR), 32'h0000);
    chk("t7_exec", 32'(EXEC), 32'h0000);
    chk("t7_exec_pc", 32'(EXEC_PC), 32'h0000);
    chk("t7_valid", 32'(EXEC_VALID), 32'd0);
    chk("t7_halted", 32'(HALTED), 32'd0);
    ticks(2);
    RESET = 1'b0;
    tick();
    chk("t7_rereq", 32'(IMEM_REQ), 32'd1);
    chk("t7_readdr", 32'(IMEM_ADDR), 32'h0000);

    // randomized traffic against the stream model
    mem_rand = 1; noise_en = 1; hlt_en = 1;
    hlt_addr = 16'($urandom_range(4, 15));
    redirect_to(16'h0000);
    cons_total = 0;
    for (int i = 0; i < 3000; i++) begin
      EXEC_READY  = ($urandom_range(0, 3) != 0);
      REDIRECT    = ($urandom_range(0, 15) == 0);
      REDIRECT_PC = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 15));
      tick();
    end
    REDIRECT = 1'b0;
    noise_en = 0;
    ticks(4);
    chk("rand_progress", 32'(cons_total > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
